key_event_gen: RTL and testbench
================================

KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 Parameter T_1MS, default 50_000, clk cycles per 1 ms tick (50 MHz clk).
REQ-002 Parameter LONG_MS, default 1000, hold time in ms before a long press is declared.
REQ-003 Parameter REPEAT_MS, default 200, auto-repeat period in ms while held after long press.
REQ-004 clk  input  1  system clock; the block has one clock domain.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 key_wave  input  1  debounced key level from upstream filter; 0 = pressed, 1 = released; synchronous to clk.
REQ-007 short_pulse  output  1  one-cycle pulse: key released before LONG_MS elapsed.
REQ-008 long_pulse  output  1  one-cycle pulse: key held for LONG_MS.
REQ-009 repeat_pulse  output  1  one-cycle pulse every REPEAT_MS while held after long_pulse.
REQ-010 key_held  output  1  level: 1 while FSM is in PRESS or HOLD.

Function
REQ-011 key_d SHALL register key_wave each cycle; press event = key_d==1 && key_wave==0.
REQ-012 FSM states SHALL be IDLE, PRESS, HOLD (one-hot, 3 bits).
REQ-013 IDLE: press event -> PRESS; tick generator and ms counter cleared on that transition.
REQ-014 PRESS: key_wave==1 -> IDLE, short_pulse asserted next cycle.
REQ-015 PRESS: key_wave==0, tick, ms_cnt==LONG_MS-1 -> HOLD, long_pulse asserted next cycle, ms_cnt cleared.
REQ-016 HOLD: key_wave==1 -> IDLE, no pulse emitted.
REQ-017 HOLD: key_wave==0, tick, ms_cnt==REPEAT_MS-1 -> stay HOLD, repeat_pulse asserted next cycle, ms_cnt cleared.
REQ-018 Tick SHALL occur every T_1MS cycles after clear; first tick T_1MS cycles after press detection.
REQ-019 ms_cnt SHALL increment on tick in PRESS/HOLD, hold otherwise; width clog2(max(LONG_MS,REPEAT_MS)); never wraps past terminal value.
REQ-020 Release and terminal tick in the same cycle: release wins (PRESS -> short_pulse only; HOLD -> no pulse).
REQ-021 All outputs SHALL be registered; at most one of short/long/repeat high in any cycle.
REQ-022 Key low at reset deassertion SHALL NOT produce an event until released then pressed again.
REQ-023 Illegal FSM state SHALL recover to IDLE next cycle with outputs 0.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, key_d 0, ms_cnt 0, tick counter 0, all outputs 0.
REQ-025 Reset asserted mid-press SHALL discard the press; no pulse emitted after reset release.

Structure
REQ-026 State encodings and default parameter values SHALL reside in shared package key_event_pkg.
REQ-027 Tick generation SHALL be sub-module ms_tick_gen (ports clk, rst_n, clr, tick; parameter T_1MS).
REQ-028 Counter widths SHALL derive from parameters via clog2; no hard-coded widths.

Verification (T_1MS=10, LONG_MS=5, REPEAT_MS=3)
REQ-029 Press 20 cycles, release -> one short_pulse, 1 cycle after release sampled; no long_pulse.
REQ-030 Hold 120 cycles -> long_pulse 51 cycles after press detection; repeat_pulse at +30, +60 after long; release -> no short_pulse.
REQ-031 Release coincident with 50th-cycle terminal tick -> short_pulse only, long_pulse never asserted.
REQ-032 rst_n low at cycle 30 of a press, key held through release of rst_n, then released -> no pulses; next press behaves per REQ-029.
REQ-033 Back-to-back: release then re-press after 1 cycle high -> two separate short_pulses, counters restarted each press.
REQ-034 Idle key_wave=1 for 1000 cycles -> all outputs 0, key_held 0.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event generator: default timing parameters,
// FSM state encoding and constant-width helpers.
package key_event_pkg;

  localparam int unsigned T_1MS_DEF     = 50_000;
  localparam int unsigned LONG_MS_DEF   = 1000;
  localparam int unsigned REPEAT_MS_DEF = 200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_PRESS = 3'b010,
    ST_HOLD  = 3'b100
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a range of v values; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms tick generator; clr restarts the period so the first
// tick lands exactly T_1MS cycles after the clear.
module ms_tick_gen
  import key_event_pkg::*;
#(
  parameter int unsigned T_1MS = T_1MS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CW   = clog2_min1(T_1MS);
  localparam logic [CW-1:0]  TERM = CW'(T_1MS - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == TERM)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == TERM);

endmodule

// File: rtl/key_event_gen.sv
// Key event generator: turns a debounced active-low key level into
// short-press, long-press and auto-repeat pulses plus a held level.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int unsigned T_1MS     = T_1MS_DEF,
  parameter int unsigned LONG_MS   = LONG_MS_DEF,
  parameter int unsigned REPEAT_MS = REPEAT_MS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_wave,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic key_held
);

  localparam int unsigned      MS_W      = clog2_min1(max_u(LONG_MS, REPEAT_MS));
  localparam logic [MS_W-1:0]  LONG_TERM = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0]  REP_TERM  = MS_W'(REPEAT_MS - 1);
  localparam logic [MS_W-1:0]  MS_MAX    = MS_W'(max_u(LONG_MS, REPEAT_MS) - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_key_d;
  logic [MS_W-1:0] r_ms_cnt;
  logic            r_short, r_long, r_repeat, r_held;
  logic            w_press_evt, w_tick, w_tick_clr, w_ms_clr, w_ms_inc;
  logic            w_short_nxt, w_long_nxt, w_repeat_nxt, w_held_nxt;

  // key_d resets to 0, so a key already low at reset release is not an event.
  assign w_press_evt = r_key_d && !key_wave;

  ms_tick_gen #(.T_1MS(T_1MS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_tick_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_clr   = 1'b0;
    w_ms_clr     = 1'b0;
    w_ms_inc     = 1'b0;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press_evt) begin
          w_state_nxt = ST_PRESS;
          w_tick_clr  = 1'b1;
          w_ms_clr    = 1'b1;
        end
      end
      ST_PRESS: begin
        if (key_wave) begin
          w_state_nxt = ST_IDLE;
          w_short_nxt = 1'b1;
        end else if (w_tick) begin
          if (r_ms_cnt == LONG_TERM) begin
            w_state_nxt = ST_HOLD;
            w_long_nxt  = 1'b1;
            w_ms_clr    = 1'b1;
          end else begin
            w_ms_inc = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (key_wave) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_ms_cnt == REP_TERM) begin
            w_repeat_nxt = 1'b1;
            w_ms_clr     = 1'b1;
          end else begin
            w_ms_inc = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ms_clr    = 1'b1;
      end
    endcase
    w_held_nxt = (w_state_nxt == ST_PRESS) || (w_state_nxt == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_d  <= 1'b0;
      r_ms_cnt <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_key_d  <= key_wave;
      if (w_ms_clr) begin
        r_ms_cnt <= '0;
      end else if (w_ms_inc && (r_ms_cnt != MS_MAX)) begin
        r_ms_cnt <= r_ms_cnt + 1'b1;
      end
      r_short  <= w_short_nxt;
      r_long   <= w_long_nxt;
      r_repeat <= w_repeat_nxt;
      r_held   <= w_held_nxt;
    end
  end

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign repeat_pulse = r_repeat;
  assign key_held     = r_held;

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: directed scenarios followed by
// random key segments, all checked against a cycle-count reference model.
module tb_key_event_gen;

  localparam int unsigned T  = 10;
  localparam int unsigned L  = 5;
  localparam int unsigned R  = 3;
  localparam int unsigned LT = T * L;
  localparam int unsigned RT = T * R;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_wave = 1'b1;
  logic short_pulse, long_pulse, repeat_pulse, key_held;

  always #5 clk = ~clk;

  key_event_gen #(.T_1MS(T), .LONG_MS(L), .REPEAT_MS(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_wave     (key_wave),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .key_held     (key_held)
  );

  int checks = 0;
  int fails  = 0;
  int unsigned cyc = 0;

  // Reference model: press age in clock edges since the detecting edge.
  bit m_prev   = 1'b0;
  bit m_active = 1'b0;
  int unsigned m_n = 0;

  int obs_s, obs_l, obs_r;
  int unsigned det_step, long_step;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr_counts();
    obs_s = 0; obs_l = 0; obs_r = 0;
    det_step = 0; long_step = 0;
  endtask

  task automatic step(input logic k);
    logic es, el, er;
    key_wave = k;
    @(posedge clk);
    cyc++;
    es = 1'b0; el = 1'b0; er = 1'b0;
    if (m_active) begin
      m_n++;
      if (k) begin
        es = (m_n <= LT);
        m_active = 1'b0;
      end else if (m_n == LT) begin
        el = 1'b1;
      end else if ((m_n > LT) && (((m_n - LT) % RT) == 0)) begin
        er = 1'b1;
      end
    end else if (m_prev && !k) begin
      m_active = 1'b1;
      m_n = 0;
      det_step = cyc;
    end
    m_prev = k;
    #1;
    check("short_pulse",  short_pulse,  es);
    check("long_pulse",   long_pulse,   el);
    check("repeat_pulse", repeat_pulse, er);
    check("key_held",     key_held,     m_active);
    obs_s += int'(short_pulse);
    obs_l += int'(long_pulse);
    obs_r += int'(repeat_pulse);
    if (long_pulse) long_step = cyc;
  endtask

  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  // Called at posedge+1; asserts reset between edges and checks async clear.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    check("rst_short",  short_pulse,  0);
    check("rst_long",   long_pulse,   0);
    check("rst_repeat", repeat_pulse, 0);
    check("rst_held",   key_held,     0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_prev = 1'b0;
    m_active = 1'b0;
  endtask

  initial begin
    clr_counts();
    #2;
    check("init_short",  short_pulse,  0);
    check("init_long",   long_pulse,   0);
    check("init_repeat", repeat_pulse, 0);
    check("init_held",   key_held,     0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle with key released
    clr_counts();
    hold(1'b1, 1000);
    check("idle_pulses", obs_s + obs_l + obs_r, 0);

    // Short press
    clr_counts();
    hold(1'b0, 20);
    hold(1'b1, 5);
    check("short_cnt", obs_s, 1);
    check("short_nolong", obs_l, 0);

    // Long press with auto-repeat; long visible just after the LT-th edge
    clr_counts();
    hold(1'b0, 120);
    hold(1'b1, 5);
    check("long_cnt", obs_l, 1);
    check("long_delay", int'(long_step - det_step), LT);
    check("repeat_cnt", obs_r, 2);
    check("long_noshort", obs_s, 0);

    // Release on the terminal tick edge
    clr_counts();
    hold(1'b0, LT);
    hold(1'b1, 5);
    check("edge_short", obs_s, 1);
    check("edge_nolong", obs_l, 0);

    // Reset mid-press with key held through reset release
    clr_counts();
    hold(1'b0, 30);
    apply_reset();
    hold(1'b0, 10);
    hold(1'b1, 5);
    check("rst_nopulse", obs_s + obs_l + obs_r, 0);
    clr_counts();
    hold(1'b0, 20);
    hold(1'b1, 5);
    check("post_rst_short", obs_s, 1);

    // Back-to-back presses with a single released cycle
    clr_counts();
    hold(1'b0, 15);
    step(1'b1);
    hold(1'b0, 15);
    hold(1'b1, 3);
    check("b2b_short", obs_s, 2);
    check("b2b_nolong", obs_l, 0);

    // Random segments
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 14) == 0) apply_reset();
      hold(seg[0], int'($urandom_range(1, 140)));
    end
    hold(1'b1, 5);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
